// File: rtl/recovery_request_arbiter_pkg.sv
// rtl/recovery_request_arbiter_pkg.sv - shared types and age helper for the RW-stage recovery arbiter
package recovery_request_arbiter_pkg;

  localparam int RRA_AL_IDX_W  = 6;
  localparam int RRA_ADDR_W    = 32;
  localparam int RRA_REFETCH_W = 3;

  localparam logic [RRA_REFETCH_W-1:0] REFETCH_TYPE_THIS_PC       = 3'd0;
  localparam logic [RRA_REFETCH_W-1:0] REFETCH_TYPE_NEXT_PC       = 3'd1;
  localparam logic [RRA_REFETCH_W-1:0] REFETCH_TYPE_BRANCH_TARGET = 3'd2;

  typedef logic [1:0] RecoveryArbState;
  localparam RecoveryArbState RA_IDLE       = 2'd0;
  localparam RecoveryArbState RA_ISSUED     = 2'd1;
  localparam RecoveryArbState RA_RECOVERING = 2'd2;

  typedef struct packed {
    logic                     valid;
    logic [RRA_AL_IDX_W-1:0]  ptr;
    logic [RRA_ADDR_W-1:0]    pc;
    logic [RRA_REFETCH_W-1:0] refetchType;
  } RecoveryReqPath;

  // Distance from the ActiveList head; modular subtraction handles pointer wrap.
  function automatic logic [RRA_AL_IDX_W-1:0] ActiveListAge(
    input logic [RRA_AL_IDX_W-1:0] ptr,
    input logic [RRA_AL_IDX_W-1:0] head
  );
    return ptr - head;
  endfunction

endpackage

// File: rtl/recovery_oldest_select.sv
// rtl/recovery_oldest_select.sv - picks the minimum-age valid candidate
// Ties resolve to the lowest input index, so callers order candidates by priority.
module recovery_oldest_select
  import recovery_request_arbiter_pkg::*;
#(
  parameter int NUM_IN = 3,
  parameter int IDX_W  = (NUM_IN > 1) ? $clog2(NUM_IN) : 1
) (
  input  logic [RRA_AL_IDX_W-1:0] headPtr,
  input  RecoveryReqPath          cand [NUM_IN],
  output logic                    anyValid,
  output logic [IDX_W-1:0]        oldestIdx,
  output RecoveryReqPath          oldest
);

  logic [RRA_AL_IDX_W-1:0] bestAge;
  logic [RRA_AL_IDX_W-1:0] curAge;

  always_comb begin
    anyValid  = 1'b0;
    oldestIdx = '0;
    oldest    = '0;
    bestAge   = '1;
    curAge    = '0;
    for (int i = 0; i < NUM_IN; i++) begin
      curAge = ActiveListAge(cand[i].ptr, headPtr);
      if (cand[i].valid && (!anyValid || curAge < bestAge)) begin
        anyValid  = 1'b1;
        oldestIdx = IDX_W'(i);
        oldest    = cand[i];
        bestAge   = curAge;
      end
    end
  end

endmodule

// File: rtl/recovery_request_arbiter.sv
// rtl/recovery_request_arbiter.sv - oldest-first arbiter issuing one RW-stage recovery at a time
// Optional hang watchdog (watchdogHang port) under RSD_RECOVERY_ARB_WATCHDOG_EN.
module recovery_request_arbiter
  import recovery_request_arbiter_pkg::*;
#(
  parameter int NUM_RW_REQ = 2,
  parameter int AL_IDX_W   = RRA_AL_IDX_W,
  parameter int ADDR_W     = RRA_ADDR_W,
  parameter int REFETCH_W  = RRA_REFETCH_W
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [AL_IDX_W-1:0]             alHeadPtr,
  input  logic [NUM_RW_REQ-1:0]           rwReqValid,
  input  logic [NUM_RW_REQ*AL_IDX_W-1:0]  rwReqPtr,
  input  logic [NUM_RW_REQ*ADDR_W-1:0]    rwReqPC,
  input  logic [NUM_RW_REQ*REFETCH_W-1:0] rwReqRefetchType,
  input  logic                            cmReqValid,
  input  logic                            unableToStartRecovery,
  input  logic                            phaseIsCommit,
  output logic                            exceptionDetectedInRwStage,
  output logic [AL_IDX_W-1:0]             recPtr,
  output logic [ADDR_W-1:0]               recPC,
  output logic [REFETCH_W-1:0]            recRefetchType,
  output logic                            pendingValid,
`ifdef RSD_RECOVERY_ARB_WATCHDOG_EN
  output logic                            watchdogHang,
`endif
  output logic                            droppedReq
);

  localparam int NUM_CAND = NUM_RW_REQ + 1;
  localparam int SEL_W    = (NUM_CAND > 1) ? $clog2(NUM_CAND) : 1;

  RecoveryArbState         state;
  RecoveryReqPath          pending;
  RecoveryReqPath          cand [NUM_CAND];
  RecoveryReqPath          sel;
  logic [NUM_CAND-1:0]     rawValid;
  logic [NUM_CAND-1:0]     selOneHot;
  logic [SEL_W-1:0]        selIdx;
  logic                    selAny;
  logic [AL_IDX_W-1:0]     recAge;
  logic [1:0]              suppressCnt;
  logic                    pulseQ;
  logic                    issue;
  logic                    dropNow;

  // Slot 0 is the pending entry so it wins age ties against fresh lanes.
  always_comb begin
    recAge      = ActiveListAge(recPtr, alHeadPtr);
    cand[0]     = pending;
    rawValid[0] = pending.valid;
    for (int i = 1; i < NUM_CAND; i++) begin
      cand[i]             = '0;
      cand[i].ptr         = rwReqPtr[(i-1)*AL_IDX_W +: AL_IDX_W];
      cand[i].pc          = rwReqPC[(i-1)*ADDR_W +: ADDR_W];
      cand[i].refetchType = rwReqRefetchType[(i-1)*REFETCH_W +: REFETCH_W];
      rawValid[i]         = rwReqValid[i-1];
    end
    // While our recovery is in flight, anything not older than it gets flushed by it.
    for (int i = 0; i < NUM_CAND; i++) begin
      cand[i].valid = rawValid[i] && !cmReqValid &&
                      (state == RA_IDLE || ActiveListAge(cand[i].ptr, alHeadPtr) < recAge);
    end
  end

  recovery_oldest_select #(
    .NUM_IN (NUM_CAND),
    .IDX_W  (SEL_W)
  ) u_oldestSelect (
    .headPtr   (alHeadPtr),
    .cand      (cand),
    .anyValid  (selAny),
    .oldestIdx (selIdx),
    .oldest    (sel)
  );

  always_comb begin
    selOneHot = '0;
    for (int i = 0; i < NUM_CAND; i++) begin
      selOneHot[i] = selAny && (selIdx == SEL_W'(i));
    end
    dropNow = |(rawValid & ~selOneHot);
    issue   = (state == RA_IDLE) && selAny && !unableToStartRecovery &&
              !cmReqValid && phaseIsCommit;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state          <= RA_IDLE;
      pending        <= '0;
      pulseQ         <= 1'b0;
      droppedReq     <= 1'b0;
      recPtr         <= '0;
      recPC          <= '0;
      recRefetchType <= REFETCH_TYPE_THIS_PC;
      suppressCnt    <= '0;
    end else begin
      pulseQ     <= issue;
      droppedReq <= dropNow;
      if (issue) begin
        recPtr         <= sel.ptr;
        recPC          <= sel.pc;
        recRefetchType <= sel.refetchType;
        pending        <= '0;
      end else if (selAny) begin
        pending <= sel;
      end else begin
        pending <= '0;
      end
      case (state)
        RA_IDLE: begin
          if (issue) begin
            state       <= RA_ISSUED;
            suppressCnt <= '0;
          end
        end
        RA_ISSUED: begin
          // Manager never left commit phase: treat the recovery as suppressed.
          if (!phaseIsCommit) begin
            state <= RA_RECOVERING;
          end else if (suppressCnt == 2'd3) begin
            state <= RA_IDLE;
          end else begin
            suppressCnt <= suppressCnt + 2'd1;
          end
        end
        RA_RECOVERING: begin
          if (phaseIsCommit) state <= RA_IDLE;
        end
        default: state <= RA_IDLE;
      endcase
    end
  end

  assign exceptionDetectedInRwStage = pulseQ && !cmReqValid;
  assign pendingValid               = pending.valid;

`ifdef RSD_RECOVERY_ARB_WATCHDOG_EN
  logic [9:0] wdCnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wdCnt        <= '0;
      watchdogHang <= 1'b0;
    end else begin
      if (issue || !pending.valid) begin
        wdCnt <= '0;
      end else if (state == RA_IDLE && wdCnt != 10'h3FF) begin
        wdCnt <= wdCnt + 10'd1;
      end
      if (wdCnt == 10'h3FF) watchdogHang <= 1'b1;
    end
  end

  RSD_ASSERT_watchdog: assert property (@(posedge clk) disable iff (!rst) wdCnt != 10'h3FF);
`endif

endmodule

// File: tb/tb_recovery_request_arbiter.sv
// tb/tb_recovery_request_arbiter.sv - directed and randomized checks for recovery_request_arbiter
module tb_recovery_request_arbiter;

  logic        clk;
  logic        rst;
  logic [5:0]  alHeadPtr;
  logic [1:0]  rwReqValid;
  logic [11:0] rwReqPtr;
  logic [63:0] rwReqPC;
  logic [5:0]  rwReqRefetchType;
  logic        cmReqValid;
  logic        unableToStartRecovery;
  logic        phaseIsCommit;
  logic        exceptionDetectedInRwStage;
  logic [5:0]  recPtr;
  logic [31:0] recPC;
  logic [2:0]  recRefetchType;
  logic        pendingValid;
  logic        droppedReq;
`ifdef RSD_RECOVERY_ARB_WATCHDOG_EN
  logic        watchdogHang;
`endif

  int tests = 0;
  int fails = 0;

  recovery_request_arbiter dut (
    .clk                        (clk),
    .rst                        (rst),
    .alHeadPtr                  (alHeadPtr),
    .rwReqValid                 (rwReqValid),
    .rwReqPtr                   (rwReqPtr),
    .rwReqPC                    (rwReqPC),
    .rwReqRefetchType           (rwReqRefetchType),
    .cmReqValid                 (cmReqValid),
    .unableToStartRecovery      (unableToStartRecovery),
    .phaseIsCommit              (phaseIsCommit),
    .exceptionDetectedInRwStage (exceptionDetectedInRwStage),
    .recPtr                     (recPtr),
    .recPC                      (recPC),
    .recRefetchType             (recRefetchType),
    .pendingValid               (pendingValid),
`ifdef RSD_RECOVERY_ARB_WATCHDOG_EN
    .watchdogHang               (watchdogHang),
`endif
    .droppedReq                 (droppedReq)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reference model: 0 = idle, 1 = issued, 2 = recovering
  typedef struct {
    int          age;
    int          prio;
    logic [5:0]  ptr;
    logic [31:0] pc;
    logic [2:0]  rt;
  } cand_t;

  int          mState;
  int          mWait;
  bit          mPendV;
  cand_t       mPend;
  logic [5:0]  mRecPtr;
  logic [31:0] mRecPC;
  logic [2:0]  mRecRt;
  bit          mPulse;
  bit          mDrop;

  function automatic int ageOf(input logic [5:0] p, input logic [5:0] h);
    return (int'(p) - int'(h) + 64) % 64;
  endfunction

  task automatic modelReset();
    mState = 0; mWait = 0; mPendV = 0;
    mPend = '{0, 0, 6'd0, 32'd0, 3'd0};
    mRecPtr = 6'd0; mRecPC = 32'd0; mRecRt = 3'd0;
    mPulse = 0; mDrop = 0;
  endtask

  task automatic modelStep();
    cand_t all[$];
    cand_t kept[$];
    cand_t best;
    int    recAge;
    bit    have;
    bit    iss;
    if (mPendV) all.push_back('{ageOf(mPend.ptr, alHeadPtr), 0, mPend.ptr, mPend.pc, mPend.rt});
    for (int l = 0; l < 2; l++) begin
      if (rwReqValid[l])
        all.push_back('{ageOf(rwReqPtr[l*6 +: 6], alHeadPtr), l + 1, rwReqPtr[l*6 +: 6],
                        rwReqPC[l*32 +: 32], rwReqRefetchType[l*3 +: 3]});
    end
    recAge = ageOf(mRecPtr, alHeadPtr);
    if (!cmReqValid) begin
      foreach (all[i]) if (mState == 0 || all[i].age < recAge) kept.push_back(all[i]);
    end
    have = kept.size() > 0;
    best = '{0, 0, 6'd0, 32'd0, 3'd0};
    if (have) begin
      best = kept[0];
      foreach (kept[i])
        if (kept[i].age < best.age || (kept[i].age == best.age && kept[i].prio < best.prio)) best = kept[i];
    end
    iss    = have && mState == 0 && !unableToStartRecovery && phaseIsCommit;
    mDrop  = all.size() > (have ? 1 : 0);
    mPulse = iss;
    if (iss) begin
      mRecPtr = best.ptr; mRecPC = best.pc; mRecRt = best.rt; mPendV = 0;
    end else if (have) begin
      mPend = best; mPendV = 1;
    end else begin
      mPendV = 0;
    end
    case (mState)
      0: if (iss) begin mState = 1; mWait = 0; end
      1: begin
        if (!phaseIsCommit) mState = 2;
        else begin
          mWait++;
          if (mWait == 4) mState = 0;
        end
      end
      default: if (phaseIsCommit) mState = 0;
    endcase
  endtask

  task automatic idleInputs();
    alHeadPtr = 6'd0; rwReqValid = 2'b00; rwReqPtr = '0; rwReqPC = '0; rwReqRefetchType = '0;
    cmReqValid = 1'b0; unableToStartRecovery = 1'b0; phaseIsCommit = 1'b1;
  endtask

  task automatic drive(input int l, input int ptr, input int pc, input int rt);
    rwReqValid[l] = 1'b1;
    rwReqPtr[l*6 +: 6] = 6'(ptr);
    rwReqPC[l*32 +: 32] = 32'(pc);
    rwReqRefetchType[l*3 +: 3] = 3'(rt);
  endtask

  task automatic tick();
    @(posedge clk);
    modelStep();
    @(negedge clk);
  endtask

  task automatic doReset();
    rst = 1'b0;
    idleInputs();
    modelReset();
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    idleInputs();
    modelReset();
    repeat (2) @(negedge clk);
    tests += 6;
    if (exceptionDetectedInRwStage !== 1'b0) begin fails++; $display("FAIL reset_pulse: got %0b want 0", exceptionDetectedInRwStage); end
    if (recPtr !== 6'd0) begin fails++; $display("FAIL reset_recPtr: got %0d want 0", recPtr); end
    if (recPC !== 32'd0) begin fails++; $display("FAIL reset_recPC: got %0h want 0", recPC); end
    if (recRefetchType !== 3'd0) begin fails++; $display("FAIL reset_refetch: got %0d want 0", recRefetchType); end
    if (pendingValid !== 1'b0) begin fails++; $display("FAIL reset_pending: got %0b want 0", pendingValid); end
    if (droppedReq !== 1'b0) begin fails++; $display("FAIL reset_dropped: got %0b want 0", droppedReq); end
    rst = 1'b1;
  endtask

  task automatic test_oldest();
    doReset();
    alHeadPtr = 6'd10;
    drive(0, 12, 'h100, 1);
    drive(1, 11, 'h200, 2);
    tick();
    rwReqValid = 2'b00;
    tests += 5;
    if (exceptionDetectedInRwStage !== 1'b1) begin fails++; $display("FAIL oldest_pulse: got %0b want 1", exceptionDetectedInRwStage); end
    if (recPtr !== 6'd11) begin fails++; $display("FAIL oldest_recPtr: got %0d want 11", recPtr); end
    if (recPC !== 32'h200) begin fails++; $display("FAIL oldest_recPC: got %0h want 200", recPC); end
    if (recRefetchType !== 3'd2) begin fails++; $display("FAIL oldest_refetch: got %0d want 2", recRefetchType); end
    if (droppedReq !== 1'b1) begin fails++; $display("FAIL oldest_dropped: got %0b want 1", droppedReq); end
    tick();
    tests += 2;
    if (exceptionDetectedInRwStage !== 1'b0) begin fails++; $display("FAIL back_to_back_pulse: got %0b want 0", exceptionDetectedInRwStage); end
    if (droppedReq !== 1'b0) begin fails++; $display("FAIL oldest_dropped_clear: got %0b want 0", droppedReq); end
  endtask

  task automatic test_wrap();
    doReset();
    alHeadPtr = 6'd60;
    drive(0, 2, 'h2, 0);
    drive(1, 62, 'h62, 1);
    tick();
    rwReqValid = 2'b00;
    tests += 3;
    if (exceptionDetectedInRwStage !== 1'b1) begin fails++; $display("FAIL wrap_pulse: got %0b want 1", exceptionDetectedInRwStage); end
    if (recPtr !== 6'd62) begin fails++; $display("FAIL wrap_recPtr: got %0d want 62", recPtr); end
    if (recPC !== 32'h62) begin fails++; $display("FAIL wrap_recPC: got %0h want 62", recPC); end
  endtask

  task automatic test_pending_replace();
    doReset();
    unableToStartRecovery = 1'b1;
    drive(0, 20, 'h20, 0);
    tick();
    rwReqValid = 2'b00;
    tests += 2;
    if (pendingValid !== 1'b1) begin fails++; $display("FAIL hold_pending: got %0b want 1", pendingValid); end
    if (droppedReq !== 1'b0) begin fails++; $display("FAIL hold_dropped: got %0b want 0", droppedReq); end
    for (int i = 0; i < 4; i++) begin
      tick();
      tests += 2;
      if (pendingValid !== 1'b1) begin fails++; $display("FAIL hold_pending_%0d: got %0b want 1", i, pendingValid); end
      if (exceptionDetectedInRwStage !== 1'b0) begin fails++; $display("FAIL hold_pulse_%0d: got %0b want 0", i, exceptionDetectedInRwStage); end
    end
    drive(0, 18, 'h18, 1);
    tick();
    rwReqValid = 2'b00;
    tests += 2;
    if (pendingValid !== 1'b1) begin fails++; $display("FAIL replace_pending: got %0b want 1", pendingValid); end
    if (droppedReq !== 1'b1) begin fails++; $display("FAIL replace_dropped: got %0b want 1", droppedReq); end
    unableToStartRecovery = 1'b0;
    tick();
    tests += 4;
    if (exceptionDetectedInRwStage !== 1'b1) begin fails++; $display("FAIL release_pulse: got %0b want 1", exceptionDetectedInRwStage); end
    if (recPtr !== 6'd18) begin fails++; $display("FAIL release_recPtr: got %0d want 18", recPtr); end
    if (recPC !== 32'h18) begin fails++; $display("FAIL release_recPC: got %0h want 18", recPC); end
    if (pendingValid !== 1'b0) begin fails++; $display("FAIL release_pending: got %0b want 0", pendingValid); end
  endtask

  task automatic test_cm_flush();
    doReset();
    unableToStartRecovery = 1'b1;
    drive(0, 20, 'h20, 0);
    tick();
    rwReqValid = 2'b00;
    cmReqValid = 1'b1;
    tick();
    tests += 3;
    if (pendingValid !== 1'b0) begin fails++; $display("FAIL cm_pending: got %0b want 0", pendingValid); end
    if (droppedReq !== 1'b1) begin fails++; $display("FAIL cm_dropped: got %0b want 1", droppedReq); end
    if (exceptionDetectedInRwStage !== 1'b0) begin fails++; $display("FAIL cm_pulse: got %0b want 0", exceptionDetectedInRwStage); end
    cmReqValid = 1'b0;
    unableToStartRecovery = 1'b0;
    tick();
    tests += 2;
    if (exceptionDetectedInRwStage !== 1'b0) begin fails++; $display("FAIL cm_after_pulse: got %0b want 0", exceptionDetectedInRwStage); end
    if (pendingValid !== 1'b0) begin fails++; $display("FAIL cm_after_pending: got %0b want 0", pendingValid); end
  endtask

  task automatic test_inflight_filter();
    doReset();
    drive(0, 30, 'h30, 0);
    tick();
    rwReqValid = 2'b00;
    tests += 2;
    if (exceptionDetectedInRwStage !== 1'b1) begin fails++; $display("FAIL inflight_pulse: got %0b want 1", exceptionDetectedInRwStage); end
    if (recPtr !== 6'd30) begin fails++; $display("FAIL inflight_recPtr: got %0d want 30", recPtr); end
    phaseIsCommit = 1'b0;
    tick();
    drive(0, 35, 'h35, 0);
    tick();
    rwReqValid = 2'b00;
    tests += 2;
    if (droppedReq !== 1'b1) begin fails++; $display("FAIL younger_dropped: got %0b want 1", droppedReq); end
    if (pendingValid !== 1'b0) begin fails++; $display("FAIL younger_pending: got %0b want 0", pendingValid); end
    drive(0, 25, 'h25, 1);
    tick();
    rwReqValid = 2'b00;
    tests += 3;
    if (pendingValid !== 1'b1) begin fails++; $display("FAIL older_pending: got %0b want 1", pendingValid); end
    if (droppedReq !== 1'b0) begin fails++; $display("FAIL older_dropped: got %0b want 0", droppedReq); end
    if (exceptionDetectedInRwStage !== 1'b0) begin fails++; $display("FAIL older_pulse: got %0b want 0", exceptionDetectedInRwStage); end
    phaseIsCommit = 1'b1;
    tick();
    tests += 2;
    if (exceptionDetectedInRwStage !== 1'b0) begin fails++; $display("FAIL return_pulse: got %0b want 0", exceptionDetectedInRwStage); end
    if (pendingValid !== 1'b1) begin fails++; $display("FAIL return_pending: got %0b want 1", pendingValid); end
    tick();
    tests += 3;
    if (exceptionDetectedInRwStage !== 1'b1) begin fails++; $display("FAIL older_issue_pulse: got %0b want 1", exceptionDetectedInRwStage); end
    if (recPtr !== 6'd25) begin fails++; $display("FAIL older_issue_recPtr: got %0d want 25", recPtr); end
    if (recRefetchType !== 3'd1) begin fails++; $display("FAIL older_issue_refetch: got %0d want 1", recRefetchType); end
  endtask

  task automatic test_suppress();
    doReset();
    drive(0, 5, 'h5, 0);
    tick();
    rwReqValid = 2'b00;
    drive(0, 3, 'h3, 0);
    tick();
    rwReqValid = 2'b00;
    tests += 2;
    if (pendingValid !== 1'b1) begin fails++; $display("FAIL suppress_pending: got %0b want 1", pendingValid); end
    if (exceptionDetectedInRwStage !== 1'b0) begin fails++; $display("FAIL suppress_pulse_0: got %0b want 0", exceptionDetectedInRwStage); end
    for (int i = 1; i < 4; i++) begin
      tick();
      tests++;
      if (exceptionDetectedInRwStage !== 1'b0) begin fails++; $display("FAIL suppress_pulse_%0d: got %0b want 0", i, exceptionDetectedInRwStage); end
    end
    tick();
    tests += 2;
    if (exceptionDetectedInRwStage !== 1'b1) begin fails++; $display("FAIL suppress_reissue: got %0b want 1", exceptionDetectedInRwStage); end
    if (recPtr !== 6'd3) begin fails++; $display("FAIL suppress_recPtr: got %0d want 3", recPtr); end
  endtask

  task automatic test_reset_mid();
    doReset();
    drive(0, 7, 'h77, 1);
    tick();
    rwReqValid = 2'b00;
    tests++;
    if (exceptionDetectedInRwStage !== 1'b1) begin fails++; $display("FAIL mid_pre_pulse: got %0b want 1", exceptionDetectedInRwStage); end
    rst = 1'b0;
    modelReset();
    #1;
    tests += 5;
    if (exceptionDetectedInRwStage !== 1'b0) begin fails++; $display("FAIL mid_pulse: got %0b want 0", exceptionDetectedInRwStage); end
    if (recPtr !== 6'd0) begin fails++; $display("FAIL mid_recPtr: got %0d want 0", recPtr); end
    if (recPC !== 32'd0) begin fails++; $display("FAIL mid_recPC: got %0h want 0", recPC); end
    if (recRefetchType !== 3'd0) begin fails++; $display("FAIL mid_refetch: got %0d want 0", recRefetchType); end
    if (pendingValid !== 1'b0) begin fails++; $display("FAIL mid_pending: got %0b want 0", pendingValid); end
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 2; i++) begin
      tick();
      tests++;
      if (exceptionDetectedInRwStage !== 1'b0) begin fails++; $display("FAIL mid_after_pulse_%0d: got %0b want 0", i, exceptionDetectedInRwStage); end
    end
  endtask

  task automatic test_random();
    doReset();
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 7) == 0) alHeadPtr = 6'($urandom_range(0, 63));
      for (int l = 0; l < 2; l++) begin
        rwReqValid[l] = ($urandom_range(0, 3) == 0);
        rwReqPtr[l*6 +: 6] = 6'($urandom_range(0, 63));
        rwReqPC[l*32 +: 32] = $urandom;
        rwReqRefetchType[l*3 +: 3] = 3'($urandom_range(0, 2));
      end
      cmReqValid = ($urandom_range(0, 19) == 0);
      unableToStartRecovery = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 3) == 0) phaseIsCommit = ~phaseIsCommit;
      #1;
      tests += 6;
      if (exceptionDetectedInRwStage !== (mPulse && !cmReqValid)) begin fails++; $display("FAIL rnd_pulse c=%0d: got %0b want %0b", c, exceptionDetectedInRwStage, mPulse && !cmReqValid); end
      if (recPtr !== mRecPtr) begin fails++; $display("FAIL rnd_recPtr c=%0d: got %0d want %0d", c, recPtr, mRecPtr); end
      if (recPC !== mRecPC) begin fails++; $display("FAIL rnd_recPC c=%0d: got %0h want %0h", c, recPC, mRecPC); end
      if (recRefetchType !== mRecRt) begin fails++; $display("FAIL rnd_refetch c=%0d: got %0d want %0d", c, recRefetchType, mRecRt); end
      if (pendingValid !== mPendV) begin fails++; $display("FAIL rnd_pending c=%0d: got %0b want %0b", c, pendingValid, mPendV); end
      if (droppedReq !== mDrop) begin fails++; $display("FAIL rnd_dropped c=%0d: got %0b want %0b", c, droppedReq, mDrop); end
      tick();
    end
  endtask

  initial begin
    test_reset();
    test_oldest();
    test_wrap();
    test_pending_replace();
    test_cm_flush();
    test_inflight_filter();
    test_suppress();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
